// File: rtl/sensor_debounce.sv
// Input conditioner for the two parking-lot beam sensors.
// Each raw level passes through a two-flop synchronizer and a debounce
// FSM. The block emits clean levels, one-cycle edge strobes and a
// saturating count of rejected glitches.
//
// Handshake note: there is no valid/ready traffic here. Every output is
// a registered level or a single-cycle strobe, meaningful on every clock.

// One sensor channel: synchronizer plus debounce FSM.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic glitch
);

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             differs;

  // The synchronized sample disagrees with the level currently published.
  assign differs = (sync2 != clean);

  // A pending change that falls back to the old level is a rejected glitch.
  // It is counted on the same edge the FSM returns to STABLE.
  assign glitch = (state == ST_PENDING) && !differs;

  // Two-flop synchronizer for the asynchronous raw level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce FSM: the new level must persist DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_STABLE;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_STABLE: begin
          if (differs) begin
            state <= ST_PENDING;
            cnt   <= ONE_CNT;
          end
        end
        ST_PENDING: begin
          if (!differs) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == LAST_CNT) begin
            clean <= sync2;
            rise  <= sync2;
            fall  <= ~sync2;
            state <= ST_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE_CNT;
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// Top level: two independent channels sharing one glitch counter.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_raw,
  input  logic       b_raw,
  output logic       a_clean,
  output logic       b_clean,
  output logic       a_rise,
  output logic       a_fall,
  output logic       b_rise,
  output logic       b_fall,
  output logic [7:0] glitch_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic       a_glitch;
  logic       b_glitch;
  logic [1:0] rejects;
  logic [8:0] glitch_sum;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .clk   (clk),
    .reset (reset),
    .raw   (a_raw),
    .clean (a_clean),
    .rise  (a_rise),
    .fall  (a_fall),
    .glitch(a_glitch)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .clk   (clk),
    .reset (reset),
    .raw   (b_raw),
    .clean (b_clean),
    .rise  (b_rise),
    .fall  (b_fall),
    .glitch(b_glitch)
  );

  // Both channels may reject in the same cycle, so the step is 0, 1 or 2.
  assign rejects    = {1'b0, a_glitch} + {1'b0, b_glitch};
  assign glitch_sum = {1'b0, glitch_count} + {7'b0, rejects};

  // Saturating glitch counter, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_count <= '0;
    end else if (glitch_sum[8]) begin
      glitch_count <= 8'hFF;
    end else begin
      glitch_count <= glitch_sum[7:0];
    end
  end

endmodule
